// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - up/down counter with wrap, saturate and one-shot modes
// Arithmetic is one bit wider than count so limit/STEP crossings never alias.
module mode_counter #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SATURATE = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_RESERVED = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);
  localparam logic [WIDTH:0]   STEP_W = {1'b0, STEP_N};

  logic [WIDTH:0]   cnt_w;
  logic [WIDTH:0]   lim_w;
  logic [WIDTH:0]   nxt_up;
  logic [WIDTH-1:0] nxt_dn;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             done_nxt;

  assign cnt_w  = {1'b0, count};
  assign lim_w  = {1'b0, limit};
  assign nxt_up = cnt_w + STEP_W;
  assign nxt_dn = count - STEP_N;

  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    done_nxt  = done;
    if (load) begin
      count_nxt = load_val;
      done_nxt  = 1'b0;
    end else if (en && !done) begin
      case (mode_t'(mode))
        MODE_WRAP: begin
          if (dir) begin
            // count above limit also lands here and wraps to 0
            if (nxt_up > lim_w) begin
              count_nxt = '0;
              tc_nxt    = 1'b1;
            end else begin
              count_nxt = nxt_up[WIDTH-1:0];
            end
          end else if (cnt_w < STEP_W) begin
            count_nxt = limit;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = nxt_dn;
          end
        end
        MODE_SATURATE, MODE_ONESHOT: begin
          if (dir) begin
            if (nxt_up >= lim_w) begin
              count_nxt = limit;
              tc_nxt    = (count != limit);
            end else begin
              count_nxt = nxt_up[WIDTH-1:0];
            end
          end else if (cnt_w <= STEP_W) begin
            count_nxt = '0;
            tc_nxt    = (count != '0);
          end else begin
            count_nxt = nxt_dn;
          end
          if (mode_t'(mode) == MODE_ONESHOT && tc_nxt) done_nxt = 1'b1;
        end
        MODE_RESERVED: begin
          count_nxt = count;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - randomized and directed bench for mode_counter
// Runs a STEP=1 and a STEP=4 instance in parallel against an integer model.
module tb_mode_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dir;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic [7:0] count1, count4;
  logic       tc1, tc4, done1, done4;

  int n_vec = 0;
  int n_err = 0;
  int m_c[2];
  int m_t[2];
  int m_d[2];
  int steps[2] = '{1, 4};

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(8), .STEP(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .limit(limit), .count(count1), .tc(tc1), .done(done1)
  );

  mode_counter #(.WIDTH(8), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .limit(limit), .count(count4), .tc(tc4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_c[k] = 0;
      m_t[k] = 0;
      m_d[k] = 0;
    end
  endtask

  // Plain integer reading of the counting rules; no width tricks needed.
  task automatic model_edge();
    int s, c, lim;
    for (int k = 0; k < 2; k++) begin
      s   = steps[k];
      c   = m_c[k];
      lim = int'(limit);
      m_t[k] = 0;
      if (load) begin
        m_c[k] = int'(load_val);
        m_d[k] = 0;
      end else if (en && m_d[k] == 0) begin
        if (mode == 2'd0) begin
          if (dir) begin
            if (c + s > lim) begin m_c[k] = 0; m_t[k] = 1; end
            else m_c[k] = c + s;
          end else begin
            if (c < s) begin m_c[k] = lim; m_t[k] = 1; end
            else m_c[k] = c - s;
          end
        end else if (mode == 2'd1 || mode == 2'd2) begin
          if (dir) begin
            if (c + s >= lim) begin m_c[k] = lim; m_t[k] = (c != lim) ? 1 : 0; end
            else m_c[k] = c + s;
          end else begin
            if (c <= s) begin m_c[k] = 0; m_t[k] = (c != 0) ? 1 : 0; end
            else m_c[k] = c - s;
          end
          if (mode == 2'd2 && m_t[k] == 1) m_d[k] = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_cnt1"}, count1, m_c[0]);
    check({tag, "_tc1"}, tc1, m_t[0]);
    check({tag, "_done1"}, done1, m_d[0]);
    check({tag, "_cnt4"}, count4, m_c[1]);
    check({tag, "_tc4"}, tc4, m_t[1]);
    check({tag, "_done4"}, done4, m_d[1]);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic e, input logic d, input logic [1:0] m,
                        input logic l, input logic [7:0] lv, input logic [7:0] lim);
    en = e; dir = d; mode = m; load = l; load_val = lv; limit = lim;
  endtask

  task automatic reset_pulse(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check({tag, "_cnt"}, count1, 0);
    check({tag, "_tc"}, tc1, 0);
    check({tag, "_done"}, done1, 0);
    check_all(tag);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    set_in(1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 8'd9);
    rst = 1'b0;
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    cycle("hold_idle");

    // WRAP up, limit 9: period of 10, tc only on the 9->0 edge
    en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle("wrap_up");
      check("wrap_up_seq", count1, i % 10);
      check("wrap_up_tc", tc1, (i % 10 == 0) ? 1 : 0);
    end

    // WRAP down from 2: 1, 0, then 9 with tc
    set_in(1'b0, 1'b0, 2'd0, 1'b1, 8'd2, 8'd9);
    cycle("wrap_dn_load");
    load = 1'b0; en = 1'b1;
    cycle("wrap_dn"); check("wrap_dn_1", count1, 1);
    cycle("wrap_dn"); check("wrap_dn_0", count1, 0);
    cycle("wrap_dn"); check("wrap_dn_9", count1, 9); check("wrap_dn_tc", tc1, 1);

    // SATURATE up with STEP=4 instance: 4, 8, 10(tc), 10
    set_in(1'b0, 1'b1, 2'd1, 1'b1, 8'd0, 8'd10);
    cycle("sat_load");
    load = 1'b0; en = 1'b1;
    cycle("sat4"); check("sat4_4", count4, 4);
    cycle("sat4"); check("sat4_8", count4, 8);
    cycle("sat4"); check("sat4_10", count4, 10); check("sat4_tc", tc4, 1);
    cycle("sat4"); check("sat4_hold", count4, 10); check("sat4_notc", tc4, 0);

    // ONESHOT down from 3: done sticks until load
    set_in(1'b0, 1'b0, 2'd2, 1'b1, 8'd3, 8'd9);
    cycle("os_load");
    load = 1'b0; en = 1'b1;
    cycle("os"); cycle("os"); cycle("os");
    check("os_zero", count1, 0); check("os_tc", tc1, 1); check("os_done", done1, 1);
    cycle("os_held"); cycle("os_held");
    check("os_held_tc", tc1, 0); check("os_held_done", done1, 1);
    load = 1'b1; load_val = 8'd5;
    cycle("os_reload");
    check("os_reload_cnt", count1, 5); check("os_reload_done", done1, 0);

    // load beats en; loaded value above limit wraps straight to 0
    set_in(1'b1, 1'b1, 2'd0, 1'b1, 8'd7, 8'd9);
    cycle("load_en"); check("load_en_cnt", count1, 7);
    load_val = 8'd200;
    cycle("load_big");
    load = 1'b0;
    cycle("past_term"); check("past_term_cnt", count1, 0); check("past_term_tc", tc1, 1);

    // limit = 0
    set_in(1'b0, 1'b1, 2'd0, 1'b1, 8'd0, 8'd0);
    cycle("lim0_load");
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("lim0_wrap"); check("lim0_wrap_tc", tc1, 1);
    end
    mode = 2'd1;
    cycle("lim0_sat"); check("lim0_sat_tc", tc1, 0);

    // async reset mid-count at 6
    set_in(1'b0, 1'b1, 2'd0, 1'b1, 8'd6, 8'd9);
    cycle("rst_load");
    load = 1'b0; en = 1'b1;
    reset_pulse("async_rst");
    cycle("after_rst"); check("after_rst_cnt", count1, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0)
        limit = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
      en       = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 24)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) reset_pulse("rand_rst");
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and data width in bits (>= 2).
REQ-002 SHALL have parameter STEP, default 1, increment/decrement magnitude (1 .. 2^WIDTH-1).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port dir  input  1  direction: 1 = up, 0 = down.
REQ-007 SHALL have port mode  input  2  00 WRAP, 01 SATURATE, 10 ONESHOT, 11 reserved.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  WIDTH  value written on load.
REQ-010 SHALL have port limit  input  WIDTH  upper bound of count range [0, limit].
REQ-011 SHALL have port count  output  WIDTH  registered count value.
REQ-012 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-013 SHALL have port done  output  1  registered sticky ONESHOT completion flag.

Function
REQ-014 Priority per edge SHALL be: load > (en and not done) > hold.
REQ-015 load SHALL set count = load_val, done = 0, tc = 0, regardless of en, mode, dir.
REQ-016 Arithmetic SHALL use WIDTH+1 bits: nxt_up = count + STEP; down test on count vs STEP; no silent modulo-2^WIDTH wrap.
REQ-017 WRAP, up: nxt_up > limit -> count = 0, tc = 1; else count = nxt_up, tc = 0.
REQ-018 WRAP, down: count < STEP -> count = limit, tc = 1; else count = count - STEP, tc = 0.
REQ-019 SATURATE, up: nxt_up >= limit -> count = limit, tc = 1 only if count != limit before edge; else count = nxt_up.
REQ-020 SATURATE, down: count <= STEP -> count = 0, tc = 1 only if count != 0 before edge; else count = count - STEP.
REQ-021 ONESHOT SHALL count exactly as SATURATE and set done = 1 on the same edge tc pulses.
REQ-022 While done = 1, en SHALL be ignored: count held, tc = 0; only load or reset clears done.
REQ-023 Mode 11 SHALL hold count, force tc = 0, leave done unchanged.
REQ-024 count > limit (via load or limit change) SHALL be treated as past terminal: up WRAP -> 0, up SATURATE/ONESHOT -> limit with tc = 1.
REQ-025 limit = 0 SHALL be legal: count stays 0 in WRAP (tc = 1 every enabled edge), first enabled edge from 0 gives no tc in SATURATE.
REQ-026 en = 0 and load = 0 SHALL hold count and done, with tc = 0.
REQ-027 tc SHALL never be high two consecutive cycles except WRAP with every step crossing terminal.
REQ-028 Changes of dir, mode, limit SHALL take effect on the next edge; no internal state beyond count, tc, done.

Reset
REQ-029 rst = 0 SHALL immediately, without clock, force count = 0, tc = 0, done = 0.
REQ-030 Reset asserted mid-count or mid-pulse SHALL abort operation; first edge after release behaves as from count = 0.
REQ-031 load and en SHALL be ignored while rst = 0.

Verification (WIDTH=8, STEP=1 unless stated)
REQ-032 WRAP up, limit=9, en=1 from reset -> count 0..9, then 0 with tc high only on that edge; period 10 cycles.
REQ-033 WRAP down, limit=9, load_val=2 -> count 2,1,0,9 with tc on transition to 9.
REQ-034 SATURATE up, STEP=4, limit=10, from 0 -> 4,8,10,10; tc pulses once on 8->10.
REQ-035 ONESHOT down, load_val=3 -> 2,1,0, done=1 with tc; further en holds 0, tc=0; load 5 clears done.
REQ-036 load and en same edge, load_val=7 -> count=7, no increment; load_val=200 with limit=9, WRAP up -> next count 0, tc=1.
REQ-037 rst pulsed low between clock edges at count=6 -> count=0, tc=0, done=0 immediately, before next edge.
